// File: rtl/btb_predictor_pkg.sv
// Shared definitions for the branch target buffer: default word size,
// prediction-mode encodings and the direction-counter reset constants.
package btb_predictor_pkg;

    // Default PC / target width of the CPU datapath.
    localparam int WORD_SIZE = 16;

    // Prediction modes.
    localparam int PRED_ANY_HIT = 0;  // any table hit redirects fetch
    localparam int PRED_CNT_MSB = 1;  // counter MSB decides, jumps always taken

    // Counter constants for the default 2-bit counter.
    localparam logic [1:0] CNT_WEAK_T  = 2'b10;
    localparam logic [1:0] CNT_WEAK_NT = 2'b01;

    // Weakly-taken for any counter width: a one followed by zeros.
    function automatic int unsigned cnt_weak_t(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    // Weakly-not-taken for any counter width: a zero followed by ones.
    function automatic int unsigned cnt_weak_nt(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch/resolve bus between the pipeline and the branch target buffer.
//
// Handshake: there is no ready. lookup_valid, upd_valid and flush_all are
// single-cycle qualifiers sampled at each rising clock edge; the predictor
// always accepts them. pred_* are combinational on lookup_pc, stat_* are
// registered.
interface btb_predictor_if #(
    parameter int WORD_SIZE = btb_predictor_pkg::WORD_SIZE
);
    logic                 lookup_valid;
    logic [WORD_SIZE-1:0] lookup_pc;
    logic                 pred_taken;
    logic [WORD_SIZE-1:0] pred_target;
    logic                 upd_valid;
    logic [WORD_SIZE-1:0] upd_pc;
    logic [WORD_SIZE-1:0] upd_target;
    logic                 upd_taken;
    logic                 upd_is_jump;
    logic                 upd_mispredict;
    logic                 flush_all;
    logic [WORD_SIZE-1:0] stat_lookups;
    logic [WORD_SIZE-1:0] stat_mispredicts;

    // Pipeline side (IF/ID stages).
    modport master (
        output lookup_valid, lookup_pc,
        output upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump, upd_mispredict,
        output flush_all,
        input  pred_taken, pred_target,
        input  stat_lookups, stat_mispredicts
    );

    // Predictor side.
    modport slave (
        input  lookup_valid, lookup_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump, upd_mispredict,
        input  flush_all,
        output pred_taken, pred_target,
        output stat_lookups, stat_mispredicts
    );
endinterface

// File: rtl/btb_predictor_sat_counter.sv
// Saturating up/down counter with synchronous reset, clear and load.
// Priority: reset > clear > load > inc > dec.
module btb_predictor_sat_counter #(
    parameter int           W       = 2,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] q
);

    // Counter register; holds at all-ones on inc and at zero on dec.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (clear) begin
            q <= CLR_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (inc) begin
            if (q != '1) q <= q + W'(1);
        end else if (dec) begin
            if (q != '0) q <= q - W'(1);
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped, tagged branch target buffer for the IF stage. Lookup is
// combinational on the fetch PC; updates from ID resolution land on the
// next clock edge. Also counts lookups and mispredicts for debug.
module btb_predictor #(
    parameter int WORD_SIZE = btb_predictor_pkg::WORD_SIZE,
    parameter int ENTRIES   = 16,
    parameter int IDX_W     = $clog2(ENTRIES),
    parameter int CNT_W     = 2,
    parameter int PRED_MODE = btb_predictor_pkg::PRED_CNT_MSB
) (
    input  logic          clk,
    input  logic          reset,
    btb_predictor_if.slave bus
);
    import btb_predictor_pkg::*;

    localparam int TAG_W = WORD_SIZE - IDX_W;
    localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(cnt_weak_t(CNT_W));
    localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(cnt_weak_nt(CNT_W));

    // Table storage: plain registers so reset and flush take one cycle.
    logic                 valid_q  [ENTRIES];
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    logic                 jump_q   [ENTRIES];
    logic [CNT_W-1:0]     cnt_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_pred;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             up_act;

    // Lookup: index/tag split of the fetch PC and the redirect decision.
    always_comb begin
        lk_idx = bus.lookup_pc[IDX_W-1:0];
        lk_tag = bus.lookup_pc[WORD_SIZE-1:IDX_W];
        lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        if (PRED_MODE == PRED_ANY_HIT) begin
            lk_pred = lk_hit;
        end else begin
            lk_pred = lk_hit && (jump_q[lk_idx] || cnt_q[lk_idx][CNT_W-1]);
        end
    end

    assign bus.pred_taken  = lk_pred;
    assign bus.pred_target = lk_pred ? target_q[lk_idx] : bus.lookup_pc + WORD_SIZE'(1);

    // Update side: hit test against the pre-update table; flush wins over update.
    always_comb begin
        up_idx = bus.upd_pc[IDX_W-1:0];
        up_tag = bus.upd_pc[WORD_SIZE-1:IDX_W];
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_act = bus.upd_valid && !bus.flush_all;
    end

    // Valid/tag/target/jump fields: written on every taken resolution.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                jump_q[i]   <= 1'b0;
            end
        end else if (bus.flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (bus.upd_valid && bus.upd_taken) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= bus.upd_target;
            jump_q[up_idx]   <= bus.upd_is_jump;
        end
    end

    // Per-entry direction counters: train on hits, seed weakly-taken on allocation.
    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        logic sel;
        assign sel = up_act && (up_idx == IDX_W'(e));

        btb_predictor_sat_counter #(
            .W       (CNT_W),
            .RST_VAL (WEAK_NT),
            .CLR_VAL (WEAK_NT)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .clear    (bus.flush_all),
            .load     (sel && !up_hit && bus.upd_taken),
            .load_val (WEAK_T),
            .inc      (sel && up_hit && bus.upd_taken),
            .dec      (sel && up_hit && !bus.upd_taken),
            .q        (cnt_q[e])
        );
    end

    // Statistics: saturating event counters, untouched by flush.
    btb_predictor_sat_counter #(
        .W       (WORD_SIZE),
        .RST_VAL ('0),
        .CLR_VAL ('0)
    ) u_stat_lookups (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .inc      (bus.lookup_valid),
        .dec      (1'b0),
        .q        (bus.stat_lookups)
    );

    btb_predictor_sat_counter #(
        .W       (WORD_SIZE),
        .RST_VAL ('0),
        .CLR_VAL ('0)
    ) u_stat_mispredicts (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .inc      (bus.upd_valid && bus.upd_mispredict),
        .dec      (1'b0),
        .q        (bus.stat_mispredicts)
    );

endmodule

// File: tb/tb_btb_predictor.sv
// Directed testbench for btb_predictor (WORD_SIZE=16, ENTRIES=16, CNT_W=2,
// PRED_MODE=1). Inputs change 1 ns after the rising edge; outputs are
// sampled before the next edge.
module tb_btb_predictor;

    localparam int W = 16;

    // Clock and reset.
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    btb_predictor_if #(.WORD_SIZE(W)) bus ();

    btb_predictor #(
        .WORD_SIZE (W),
        .ENTRIES   (16),
        .CNT_W     (2),
        .PRED_MODE (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Scoreboard state.
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          n_lk  = 0;
    int          n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat16(input int n);
        return (n > 32'hFFFF) ? 32'hFFFF : 32'(n);
    endfunction

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.lookup_valid   = 1'b0;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = '0;
        bus.upd_target     = '0;
        bus.upd_taken      = 1'b0;
        bus.upd_is_jump    = 1'b0;
        bus.upd_mispredict = 1'b0;
        bus.flush_all      = 1'b0;
    endtask

    task automatic set_upd(input logic [W-1:0] pc, input logic [W-1:0] tgt,
                           input logic taken, input logic jump, input logic mis);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_target     = tgt;
        bus.upd_taken      = taken;
        bus.upd_is_jump    = jump;
        bus.upd_mispredict = mis;
        if (mis) n_mis++;
    endtask

    task automatic upd(input logic [W-1:0] pc, input logic [W-1:0] tgt,
                       input logic taken, input logic jump, input logic mis);
        set_upd(pc, tgt, taken, jump, mis);
        tick();
        idle();
    endtask

    task automatic do_flush();
        bus.flush_all = 1'b1;
        tick();
        idle();
    endtask

    task automatic look(input string tag, input logic [W-1:0] pc,
                        input logic exp_taken, input logic [W-1:0] exp_target);
        logic [31:0] got;
        bus.lookup_pc = pc;
        exp_q.push_back({15'd0, exp_taken, exp_target});
        #1;
        got = {15'd0, bus.pred_taken, bus.pred_target};
        check_eq(tag, got, exp_q.pop_front());
    endtask

    task automatic check_stats(input string tag);
        check_eq({tag, "_lookups"}, {16'd0, bus.stat_lookups}, sat16(n_lk));
        check_eq({tag, "_mispred"}, {16'd0, bus.stat_mispredicts}, sat16(n_mis));
    endtask

    // Directed sequence.
    initial begin
        idle();
        bus.lookup_pc = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state.
        look("reset_lookup", 16'h0005, 1'b0, 16'h0006);
        check_stats("reset");

        // Allocation on taken miss; same index, other tag misses.
        upd(16'h0013, 16'h0040, 1'b1, 1'b0, 1'b1);
        look("alloc_hit", 16'h0013, 1'b1, 16'h0040);
        look("alias_miss", 16'h0003, 1'b0, 16'h0004);

        // Not-taken miss leaves the table alone.
        upd(16'h0030, 16'h0099, 1'b0, 1'b0, 1'b0);
        look("nt_miss_noalloc", 16'h0030, 1'b0, 16'h0031);

        // Saturation then hysteresis: 10 -> 11 -> 11 -> 11 -> 10 -> 01.
        repeat (3) upd(16'h0013, 16'h0040, 1'b1, 1'b0, 1'b0);
        upd(16'h0013, 16'h0040, 1'b0, 1'b0, 1'b1);
        look("hyst_one_nt", 16'h0013, 1'b1, 16'h0040);
        upd(16'h0013, 16'h0040, 1'b0, 1'b0, 1'b1);
        look("hyst_two_nt", 16'h0013, 1'b0, 16'h0014);

        // Jumps stay taken regardless of the counter.
        upd(16'h0020, 16'h0100, 1'b1, 1'b1, 1'b0);
        repeat (4) upd(16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0);
        look("jump_sticky", 16'h0020, 1'b1, 16'h0100);

        // Flush invalidates everything but keeps statistics.
        do_flush();
        look("flush_jump", 16'h0020, 1'b0, 16'h0021);
        check_stats("flush");

        // Same-cycle lookup sees pre-update contents.
        set_upd(16'h0007, 16'h0050, 1'b1, 1'b0, 1'b0);
        look("same_cycle_old", 16'h0007, 1'b0, 16'h0008);
        tick();
        idle();
        look("same_cycle_new", 16'h0007, 1'b1, 16'h0050);

        // Update in a flush cycle is dropped.
        set_upd(16'h0008, 16'h0060, 1'b1, 1'b0, 1'b0);
        bus.flush_all = 1'b1;
        look("flush_upd_before", 16'h0008, 1'b0, 16'h0009);
        tick();
        idle();
        look("flush_upd_after", 16'h0008, 1'b0, 16'h0009);
        look("flush_upd_other", 16'h0007, 1'b0, 16'h0008);

        // Long run: lookup counter saturates, mispredicts keep counting.
        bus.lookup_pc = 16'h0005;
        for (int i = 0; i < 70000; i++) begin
            bus.lookup_valid = 1'b1;
            if (i % 1000 == 0) begin
                set_upd(16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1);
            end else begin
                bus.upd_valid      = 1'b0;
                bus.upd_mispredict = 1'b0;
            end
            tick();
            n_lk++;
            if (i == 39999) check_stats("mid_run");
        end
        idle();
        check_stats("saturated");
        look("wrap_target", 16'hFFFF, 1'b0, 16'h0000);

        // Reset mid-operation clears table and stats, drops the update.
        upd(16'h0013, 16'h0040, 1'b1, 1'b0, 1'b0);
        look("pre_reset_hit", 16'h0013, 1'b1, 16'h0040);
        set_upd(16'h0022, 16'h0070, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        n_lk  = 0;
        n_mis = 0;
        look("post_reset_old", 16'h0013, 1'b0, 16'h0014);
        look("post_reset_upd", 16'h0022, 1'b0, 16'h0023);
        check_stats("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters, used at the IF stage of the pipelined CPU.
- Replaces the fixed next-PC guess with a tagged, direct-mapped table.
- Lookup is combinational on the fetch PC.
- The table updates from branch/jump resolution in ID, and keeps lookup and mispredict statistics for the num_inst/debug path.

Parameters:
- WORD_SIZE, 16, PC/target width in bits.
- ENTRIES, 16, number of table entries; power of two, 2..256.
- IDX_W, $clog2(ENTRIES), index width (derived; do not override).
- CNT_W, 2, direction counter width in bits, 1..3.
- PRED_MODE, 1. 0 = any hit predicts taken; 1 = counter MSB decides (jumps are always taken).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- lookup_valid  input  1  IF holds a real fetch this cycle (not a stall); gates statistics only
- lookup_pc  input  WORD_SIZE  current fetch PC
- pred_taken  output  1  predicted redirect
- pred_target  output  WORD_SIZE  predicted next PC
- upd_valid  input  1  resolution event this cycle
- upd_pc  input  WORD_SIZE  PC of the resolved instruction
- upd_target  input  WORD_SIZE  resolved target
- upd_taken  input  1  branch/jump was actually taken
- upd_is_jump  input  1  unconditional jump (JMP/JAL/JR)
- upd_mispredict  input  1  resolution disagreed with the prediction
- flush_all  input  1  invalidate whole table (context change)
- stat_lookups  output  WORD_SIZE  counted lookups, saturating
- stat_mispredicts  output  WORD_SIZE  counted mispredicts, saturating

Behaviour:
- Address split: idx = pc[IDX_W-1:0]; tag = pc[WORD_SIZE-1:IDX_W].
- Entry fields: valid, tag, target, is_jump, cnt[CNT_W-1:0].
- Lookup (combinational, zero latency):
  - hit = valid[idx] & tag match.
  - PRED_MODE 1: pred_taken = hit & (is_jump | cnt MSB).
  - PRED_MODE 0: pred_taken = hit.
  - pred_target = pred_taken ? target : lookup_pc+1, modulo 2^WORD_SIZE (0xFFFF+1 wraps to 0x0000).
- Update (registered, visible from the next cycle), when upd_valid:
  - Taken and hit: rewrite target and is_jump; cnt increments, saturating at all-ones.
  - Taken and miss: allocate/replace the entry; valid=1, tag, target, is_jump written; cnt = weakly-taken (1 followed by zeros, i.e. 2'b10).
  - Not-taken and hit: cnt decrements, saturating at 0; entry stays valid.
  - Not-taken and miss: no change.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (no bypass).
- flush_all: next edge clears all valid bits and sets every cnt to weakly-not-taken (0 followed by ones, i.e. 2'b01). Statistics are not cleared.
- Priority: reset > flush_all > update. An update in a flush cycle is dropped.
- Statistics:
  - stat_lookups += 1 each cycle lookup_valid=1.
  - stat_mispredicts += 1 each cycle upd_valid & upd_mispredict.
  - Both hold at 0xFFFF (all-ones) once saturated.
- Reset values:
  - all valid=0, all cnt=weakly-not-taken, targets/tags=0.
  - stat_lookups=0, stat_mispredicts=0.
  - Outputs after reset: pred_taken=0, pred_target=lookup_pc+1.
- Reset asserted mid-operation: table and statistics are cleared on that edge; a concurrent update is lost.
- Every table bit is a register with an explicit reset (no memory inference), so reset and flush are single-cycle.

Decomposition:
- Shared package/include (alongside the opcode and control-field defines): WORD_SIZE, the PRED_MODE encodings, and the counter reset constants CNT_WEAK_T and CNT_WEAK_NT.
- One natural sub-module: sat_counter (parametrised width, inc/dec/load/clear), instantiated per entry and reused for the two statistics counters.

Test Plan:
- Reset, then lookup_pc=0x0005 -> pred_taken=0, pred_target=0x0006; both stats read 0.
- Taken update pc=0x0013, target=0x0040 (ENTRIES=16); next cycle lookup 0x0013 -> taken, target 0x0040. Lookup 0x0003 (same idx, different tag) -> not taken, target 0x0004.
- Saturation and hysteresis on pc=0x0013: three taken updates, then one not-taken -> still predicted taken. A second not-taken -> not taken.
- Jump update upd_is_jump=1, pc=0x0020, target=0x0100; then four not-taken updates -> still predicted taken. Then flush_all -> lookup 0x0020 not taken; stats unchanged.
- Same cycle: update pc=0x0007 taken, target=0x0050, and lookup 0x0007 -> not taken that cycle, taken the following cycle. Repeat with flush_all=1 in the update cycle -> entry never allocated.
- lookup_valid held high for 70000 cycles with upd_mispredict pulses -> stat_lookups saturates at 0xFFFF. lookup_pc=0xFFFF on a miss -> pred_target=0x0000.
